div_seq: RTL and testbench

Parametrised sequential unsigned integer divider that computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor. It uses a restoring algorithm that resolves one quotient bit per clock. It sits beside the combinational divider in the arithmetic estudo blocks for widths where a single-cycle divider is too large or too slow. Operands and results move over valid/ready handshakes, and a divide-by-zero flag is reported.

---
 rtl/div_seq_if.sv | 27 ++
 rtl/div_seq.sv | 126 ++++++++++++
 tb/tb_div_seq.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// div_seq_if: operand/result handshake bundle for the sequential divider.
//   in_valid/in_ready  : operand handshake carrying D (dividend) and d (divisor)
//   out_valid/out_ready: result handshake carrying q, r and dbz
//   master modport     : producer/consumer side; slave modport: the divider
interface div_seq_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;

    modport master (
        output in_valid, D, d, out_ready,
        input  in_ready, out_valid, q, r, dbz
    );

    modport slave (
        input  in_valid, D, d, out_ready,
        output in_ready, out_valid, q, r, dbz
    );
endinterface

// File: rtl/div_seq.sv
// div_seq: restoring unsigned divider, one quotient bit per clock, MSB first.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : div_seq_if slave (operands in, quotient/remainder/divide-by-zero out)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | in_ready high; accept operands, d==0 short-cuts to DONE
// RUN   | one trial subtraction per cycle, count walks WIDTH-1..0
// DONE  | out_valid high; results held until out_ready
module div_seq #(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    div_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic             dbz_r;

    logic             accept;
    logic             in_ready_c;
    logic             out_valid_c;

    // Partial remainder is always < d, so WIDTH bits hold it; the trial value
    // needs one extra bit so the compare against d cannot overflow.
    logic [WIDTH:0]   rem_t;
    logic             ge;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    always_comb begin
        rem_t   = {rem, dvd[cnt]};
        ge      = rem_t >= {1'b0, dvs};
        // When ge holds the true difference is < d, so the low WIDTH bits of
        // the modular subtraction are exact.
        rem_nxt = ge ? (rem_t[WIDTH-1:0] - dvs) : rem_t[WIDTH-1:0];
        quo_nxt = quo;
        quo_nxt[cnt] = ge;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = (bus.d == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are forced low while reset is asserted so the
    // reset cycle itself never advertises readiness or a stale result.
    assign bus.in_ready  = in_ready_c  & ~rst;
    assign bus.out_valid = out_valid_c & ~rst;
    assign bus.q         = q_r;
    assign bus.r         = r_r;
    assign bus.dbz       = dbz_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            quo   <= '0;
            q_r   <= '0;
            r_r   <= '0;
            dbz_r <= 1'b0;
        end else if (accept) begin
            if (bus.d == '0) begin
                q_r   <= '1;
                r_r   <= bus.D;
                dbz_r <= 1'b1;
            end else begin
                dvd   <= bus.D;
                dvs   <= bus.d;
                rem   <= '0;
                quo   <= '0;
                cnt   <= CW'(WIDTH - 1);
                dbz_r <= 1'b0;
            end
        end else if (state == RUN) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            if (cnt == '0) begin
                // Published results change only here, so they stay put
                // through RUN until the new result lands.
                q_r <= quo_nxt;
                r_r <= rem_nxt;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    div_seq_if #(.WIDTH(8))  bus8 ();
    div_seq_if #(.WIDTH(16)) bus16 ();

    div_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    div_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op8(input logic [7:0] dd, input logic [7:0] dv,
                          output logic [7:0] qo, output logic [7:0] ro,
                          output logic dbzo, output int lat);
        int n;
        n = 0;
        while (!bus8.in_ready && n < 50) begin step(); n++; end
        tests_run++;
        if (bus8.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL op8_wait_ready: in_ready=%b required 1", bus8.in_ready);
        end
        bus8.D = dd; bus8.d = dv; bus8.in_valid = 1'b1;
        step();
        bus8.in_valid = 1'b0;
        lat = 1;
        while (!bus8.out_valid && lat < 40) begin step(); lat++; end
        qo = bus8.q; ro = bus8.r; dbzo = bus8.dbz;
        bus8.out_ready = 1'b1;
        step();
        bus8.out_ready = 1'b0;
    endtask

    task automatic do_op16(input logic [15:0] dd, input logic [15:0] dv,
                           output logic [15:0] qo, output logic [15:0] ro,
                           output logic dbzo, output int lat);
        int n;
        n = 0;
        while (!bus16.in_ready && n < 50) begin step(); n++; end
        tests_run++;
        if (bus16.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL op16_wait_ready: in_ready=%b required 1", bus16.in_ready);
        end
        bus16.D = dd; bus16.d = dv; bus16.in_valid = 1'b1;
        step();
        bus16.in_valid = 1'b0;
        lat = 1;
        while (!bus16.out_valid && lat < 60) begin step(); lat++; end
        qo = bus16.q; ro = bus16.r; dbzo = bus16.dbz;
        bus16.out_ready = 1'b1;
        step();
        bus16.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        tests_run++;
        if (bus8.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_ready_during: got %b required 0", bus8.in_ready);
        end
        step();
        rst = 1'b0;
        #1;
        tests_run++;
        if ({bus8.in_ready, bus8.out_valid, bus8.q, bus8.r, bus8.dbz} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b q=%0d r=%0d dbz=%b required 1 0 0 0 0",
                     bus8.in_ready, bus8.out_valid, bus8.q, bus8.r, bus8.dbz);
        end
        tests_run++;
        if ({bus16.in_ready, bus16.out_valid, bus16.q, bus16.r} !== {1'b1, 1'b0, 16'd0, 16'd0}) begin
            tests_failed++;
            $display("FAIL reset_values16: in_ready=%b out_valid=%b q=%0d r=%0d required 1 0 0 0",
                     bus16.in_ready, bus16.out_valid, bus16.q, bus16.r);
        end
    endtask

    task automatic test_basic();
        logic [7:0] vd [6] = '{8'd15, 8'd0, 8'd255, 8'd3,   8'd9, 8'd200};
        logic [7:0] vv [6] = '{8'd2,  8'd2, 8'd1,   8'd200, 8'd9, 8'd13};
        logic [7:0] eq [6] = '{8'd7,  8'd0, 8'd255, 8'd0,   8'd1, 8'd15};
        logic [7:0] er [6] = '{8'd1,  8'd0, 8'd0,   8'd3,   8'd0, 8'd5};
        logic [7:0] qo, ro;
        logic dbzo;
        int lat;
        for (int i = 0; i < 6; i++) begin
            do_op8(vd[i], vv[i], qo, ro, dbzo, lat);
            tests_run++;
            if (qo !== eq[i] || ro !== er[i] || dbzo !== 1'b0 || lat != 9) begin
                tests_failed++;
                $display("FAIL basic_%0d: D=%0d d=%0d got q=%0d r=%0d dbz=%b lat=%0d required q=%0d r=%0d dbz=0 lat=9",
                         i, vd[i], vv[i], qo, ro, dbzo, lat, eq[i], er[i]);
            end
        end
        tests_run++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_ready_after_hs: in_ready=%b out_valid=%b required 1 0",
                     bus8.in_ready, bus8.out_valid);
        end
    endtask

    task automatic test_dbz();
        logic [7:0] qo, ro;
        logic dbzo;
        int lat;
        do_op8(8'd200, 8'd0, qo, ro, dbzo, lat);
        tests_run++;
        if (qo !== 8'd255 || ro !== 8'd200 || dbzo !== 1'b1 || lat != 1) begin
            tests_failed++;
            $display("FAIL dbz: got q=%0d r=%0d dbz=%b lat=%0d required q=255 r=200 dbz=1 lat=1",
                     qo, ro, dbzo, lat);
        end
        do_op8(8'd9, 8'd3, qo, ro, dbzo, lat);
        tests_run++;
        if (qo !== 8'd3 || ro !== 8'd0 || dbzo !== 1'b0 || lat != 9) begin
            tests_failed++;
            $display("FAIL dbz_next: got q=%0d r=%0d dbz=%b lat=%0d required q=3 r=0 dbz=0 lat=9",
                     qo, ro, dbzo, lat);
        end
    endtask

    task automatic test_backpressure();
        int n;
        bus8.D = 8'd100; bus8.d = 8'd7; bus8.in_valid = 1'b1;
        step();
        // Stray operand pulses while busy must be ignored.
        bus8.D = 8'd1; bus8.d = 8'd1;
        n = 0;
        while (!bus8.out_valid && n < 40) begin
            bus8.in_valid = n[0];
            tests_run++;
            if (bus8.in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_in_ready_run: cycle %0d got %b required 0", n, bus8.in_ready);
            end
            step();
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            bus8.in_valid = i[0];
            tests_run++;
            if (bus8.out_valid !== 1'b1 || bus8.q !== 8'd14 || bus8.r !== 8'd2 || bus8.in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold: cycle %0d out_valid=%b q=%0d r=%0d in_ready=%b required 1 14 2 0",
                         i, bus8.out_valid, bus8.q, bus8.r, bus8.in_ready);
            end
            step();
        end
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        step();
        bus8.out_ready = 1'b0;
        tests_run++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.q !== 8'd14 || bus8.r !== 8'd2) begin
            tests_failed++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b q=%0d r=%0d required 1 0 14 2",
                     bus8.in_ready, bus8.out_valid, bus8.q, bus8.r);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] qo, ro;
        logic dbzo;
        int lat;
        bus8.D = 8'd77; bus8.d = 8'd5; bus8.in_valid = 1'b1;
        step();
        bus8.in_valid = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus8.out_valid !== 1'b0 || bus8.q !== 8'd0 || bus8.r !== 8'd0 || bus8.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_values: out_valid=%b q=%0d r=%0d in_ready=%b required 0 0 0 1",
                     bus8.out_valid, bus8.q, bus8.r, bus8.in_ready);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            tests_run++;
            if (bus8.out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL midrst_no_result: cycle %0d out_valid=%b required 0", i, bus8.out_valid);
            end
        end
        do_op8(8'd77, 8'd5, qo, ro, dbzo, lat);
        tests_run++;
        if (qo !== 8'd15 || ro !== 8'd2 || dbzo !== 1'b0 || lat != 9) begin
            tests_failed++;
            $display("FAIL midrst_redo: got q=%0d r=%0d dbz=%b lat=%0d required q=15 r=2 dbz=0 lat=9",
                     qo, ro, dbzo, lat);
        end
    endtask

    task automatic test_w16();
        logic [15:0] vd [3] = '{16'd65535, 16'd1000, 16'd65535};
        logic [15:0] vv [3] = '{16'd255,   16'd7,    16'd1};
        logic [15:0] eq [3] = '{16'd257,   16'd142,  16'd65535};
        logic [15:0] er [3] = '{16'd0,     16'd6,    16'd0};
        logic [15:0] qo, ro;
        logic dbzo;
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_op16(vd[i], vv[i], qo, ro, dbzo, lat);
            tests_run++;
            if (qo !== eq[i] || ro !== er[i] || dbzo !== 1'b0 || lat != 17) begin
                tests_failed++;
                $display("FAIL w16_%0d: got q=%0d r=%0d dbz=%b lat=%0d required q=%0d r=%0d dbz=0 lat=17",
                         i, qo, ro, dbzo, lat, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0]  q8, r8, a8, b8;
        logic [15:0] q16, r16, a16, b16;
        logic dbzo;
        int lat;
        for (int i = 0; i < 1500; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom_range(1, 255));
            do_op8(a8, b8, q8, r8, dbzo, lat);
            tests_run++;
            if (32'(q8) * 32'(b8) + 32'(r8) != 32'(a8) || r8 >= b8 || dbzo !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand8: D=%0d d=%0d got q=%0d r=%0d dbz=%b required q=%0d r=%0d dbz=0",
                         a8, b8, q8, r8, dbzo, a8 / b8, a8 % b8);
            end
        end
        for (int i = 0; i < 1500; i++) begin
            a16 = 16'($urandom);
            b16 = (i < 750) ? 16'($urandom_range(1, 65535)) : 16'($urandom_range(1, 300));
            do_op16(a16, b16, q16, r16, dbzo, lat);
            tests_run++;
            if (32'(q16) * 32'(b16) + 32'(r16) != 32'(a16) || r16 >= b16 || dbzo !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand16: D=%0d d=%0d got q=%0d r=%0d dbz=%b required q=%0d r=%0d dbz=0",
                         a16, b16, q16, r16, dbzo, a16 / b16, a16 % b16);
            end
        end
    endtask

    initial begin
        bus8.in_valid = 1'b0;  bus8.out_ready = 1'b0;  bus8.D = '0;  bus8.d = '0;
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.D = '0; bus16.d = '0;
        test_reset();
        test_basic();
        test_dbz();
        test_backpressure();
        test_mid_reset();
        test_w16();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
